exe_muldiv: RTL and testbench
=============================

EXE_MULDIV -- requirements
Module: exe_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width; power of two, >= 8.
REQ-002 SHALL have parameter RADDR_WIDTH, default 5: register address width.
REQ-003 SHALL have parameter BITS_PER_CYCLE, default 1: multiply/divide bits retired per iteration; one of 1, 2, 4; divides XLEN. ITER = XLEN/BITS_PER_CYCLE.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush_i  input  1  abort any in-flight operation.
REQ-007 SHALL have port valid_i  input  1  operation offered this cycle.
REQ-008 SHALL have port ready_o  output  1  unit can accept; high only in IDLE.
REQ-009 SHALL have ports op1_i, op2_i  input  XLEN  source operands; op2_i carries the sign-extended immediate for OP-IMM.
REQ-010 SHALL have port inst_i  input  32  instruction word.
REQ-011 SHALL have ports reg_we_i  input  1, and reg_waddr_i  input  RADDR_WIDTH  writeback control.
REQ-012 SHALL have port valid_o  output  1  result strobe, one cycle per accepted operation.
REQ-013 SHALL have ports reg_we_o  output  1, reg_waddr_o  output  RADDR_WIDTH, and reg_wdata_o  output  XLEN  registered writeback.
REQ-014 SHALL have port busy_o  output  1  a multiply/divide is iterating.

Function
REQ-015 Accept SHALL mean valid_i && ready_o && !flush_i at a rising edge; all inputs are sampled at that edge only.
REQ-016 States SHALL be IDLE, ITERATE, DONE: IDLE->ITERATE on accepting MUL*/DIV*/REM* without a special case; ITERATE->DONE after ITER iterations; DONE->IDLE unconditionally.
REQ-017 OP-IMM (0010011) and OP (0110011, funct7 0000000/0100000) ops SHALL complete with latency 1: valid_o and result registered on the edge after accept, state stays IDLE.
REQ-018 Supported ALU ops SHALL be ADD/ADDI, SUB, SLL/SLLI, SLT/SLTI (true signed compare), SLTU/SLTIU, XOR/XORI, OR/ORI, AND/ANDI, SRL/SRLI, SRA/SRAI; shift amount = op2_i[log2(XLEN)-1:0]; inst_i[30] selects SUB and arithmetic shift.
REQ-019 OP with funct7 0000001 SHALL execute MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU per RV32M semantics at width XLEN; MUL returns the low XLEN bits, MULH* the high XLEN bits of the 2*XLEN product.
REQ-020 An iterative op SHALL raise valid_o exactly ITER+1 cycles after the accepting edge; busy_o is high in ITERATE and DONE.
REQ-021 Divide by zero SHALL complete with latency 1: quotient all ones, remainder = op1_i.
REQ-022 Signed overflow (op1 = -2^(XLEN-1), op2 = -1) SHALL complete with latency 1: DIV quotient = op1_i, REM remainder 0.
REQ-023 Signed operands SHALL be converted to magnitudes; quotient sign = sign(op1) XOR sign(op2), remainder sign = sign(op1).
REQ-024 Any other opcode/funct combination SHALL complete with latency 1: valid_o=1, reg_we_o=0, reg_waddr_o=0, reg_wdata_o=0.
REQ-025 When valid_o=1 and the op is supported, reg_we_o SHALL equal the latched reg_we_i and reg_waddr_o the latched reg_waddr_i; when valid_o=0, reg_we_o SHALL be 0.
REQ-026 flush_i SHALL return the unit to IDLE at the next edge from any state, with no valid_o for the aborted op; flush_i with valid_i in IDLE drops the input.
REQ-027 valid_i while ready_o=0 SHALL be ignored; upstream holds the op.
REQ-028 valid_o SHALL be a single-cycle pulse; there is no output backpressure.

Reset
REQ-029 With rst_i high at an edge, the unit SHALL enter IDLE with valid_o=0, reg_we_o=0, reg_waddr_o=0, reg_wdata_o=0, busy_o=0, ready_o=1 after that edge; reset overrides flush_i and valid_i, including mid-iteration.

Verification
REQ-030 ADDI op1=5, op2=0xFFFFFFFD, waddr=3 -> next cycle valid_o=1, we=1, waddr=3, wdata=2.
REQ-031 SLT op1=0xFFFFFFFF, op2=1 -> wdata=1; SLTU same operands -> wdata=0.
REQ-032 DIV op1=7, op2=0xFFFFFFFE, BPC=1 -> valid_o exactly 33 cycles after accept, wdata=0xFFFFFFFD; REM same operands -> wdata=1.
REQ-033 MULHU op1=op2=0xFFFFFFFF -> wdata=0xFFFFFFFE; MUL -> wdata=1; repeat with BPC=4 -> valid_o exactly 9 cycles after accept.
REQ-034 DIVU op2=0 -> 1-cycle wdata=0xFFFFFFFF; DIV 0x80000000 by 0xFFFFFFFF -> 1-cycle wdata=0x80000000.
REQ-035 flush_i at iteration 10 of a DIV -> no valid_o, ready_o=1 next cycle; rst_i mid-MUL -> all outputs zero next cycle, next ADD executes correctly.

Source files
------------

// File: rtl/exe_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : exe_muldiv
// Brief   : Integer execute unit with a single-cycle ALU and an iterative
//           shift-add multiplier / restoring divider for the RV32M ops.
// Rev     : 1.0
// ============================================================================

module exe_muldiv #(
    parameter int XLEN           = 32,
    parameter int RADDR_WIDTH    = 5,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [XLEN-1:0]        op1_i,
    input  logic [XLEN-1:0]        op2_i,
    input  logic [31:0]            inst_i,
    input  logic                   reg_we_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    output logic                   valid_o,
    output logic                   reg_we_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic [XLEN-1:0]        reg_wdata_o,
    output logic                   busy_o
);

    localparam int c_ITER  = XLEN / BITS_PER_CYCLE;
    localparam int c_CNT_W = $clog2(c_ITER);
    localparam int c_SHW   = $clog2(XLEN);

    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_ITER - 1);
    localparam logic [XLEN-1:0]    c_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [6:0] c_OPC_OP  = 7'b0110011;
    localparam logic [6:0] c_OPC_IMM = 7'b0010011;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ITERATE = 2'd1;
    localparam logic [1:0] c_DONE    = 2'd2;

    logic [1:0]             r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [2*XLEN-1:0]      r_acc;
    logic [XLEN-1:0]        r_opb;
    logic [2:0]             r_f3;
    logic                   r_neg;
    logic                   r_op_we;
    logic [RADDR_WIDTH-1:0] r_op_waddr;
    logic                   r_valid;
    logic                   r_we;
    logic [RADDR_WIDTH-1:0] r_waddr;
    logic [XLEN-1:0]        r_wdata;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic            w_is_op;
    logic            w_is_imm;
    logic            w_is_m;
    logic            w_f7_base;
    logic            w_f7_alt;
    logic [c_SHW-1:0] w_shamt;
    logic [XLEN-1:0] w_sra;
    logic            w_alu_ok;
    logic [XLEN-1:0] w_alu_res;
    logic            w_unused_inst;

    assign w_opcode  = inst_i[6:0];
    assign w_funct3  = inst_i[14:12];
    assign w_funct7  = inst_i[31:25];
    assign w_is_op   = (w_opcode == c_OPC_OP);
    assign w_is_imm  = (w_opcode == c_OPC_IMM);
    assign w_f7_base = (w_funct7 == 7'b0000000);
    assign w_f7_alt  = (w_funct7 == 7'b0100000);
    assign w_is_m    = w_is_op && (w_funct7 == 7'b0000001);
    assign w_shamt   = op2_i[c_SHW-1:0];
    assign w_sra     = $signed(op1_i) >>> w_shamt;
    assign w_unused_inst = ^{inst_i[24:15], inst_i[11:7]};

    always_comb begin
        w_alu_ok  = 1'b0;
        w_alu_res = '0;
        if (w_is_imm) begin
            case (w_funct3)
                3'b001:  w_alu_ok = w_f7_base;
                3'b101:  w_alu_ok = w_f7_base || w_f7_alt;
                default: w_alu_ok = 1'b1;
            endcase
        end else if (w_is_op) begin
            w_alu_ok = w_f7_base || (w_f7_alt && (w_funct3 == 3'b000 || w_funct3 == 3'b101));
        end
        // ADDI never subtracts: its bit 30 is an immediate bit
        case (w_funct3)
            3'b000:  w_alu_res = (w_is_op && inst_i[30]) ? op1_i - op2_i : op1_i + op2_i;
            3'b001:  w_alu_res = op1_i << w_shamt;
            3'b010:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(op1_i) < $signed(op2_i))};
            3'b011:  w_alu_res = {{(XLEN-1){1'b0}}, (op1_i < op2_i)};
            3'b100:  w_alu_res = op1_i ^ op2_i;
            3'b101:  w_alu_res = inst_i[30] ? w_sra : op1_i >> w_shamt;
            3'b110:  w_alu_res = op1_i | op2_i;
            default: w_alu_res = op1_i & op2_i;
        endcase
    end

    // Operand magnitudes and result sign for the iterative path
    logic            w_s1;
    logic            w_s2;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic            w_neg;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_special;

    assign w_s1   = op1_i[XLEN-1] & (w_funct3 == 3'b001 || w_funct3 == 3'b010 ||
                                     w_funct3 == 3'b100 || w_funct3 == 3'b110);
    assign w_s2   = op2_i[XLEN-1] & (w_funct3 == 3'b001 || w_funct3 == 3'b100 ||
                                     w_funct3 == 3'b110);
    assign w_mag1 = w_s1 ? -op1_i : op1_i;
    assign w_mag2 = w_s2 ? -op2_i : op2_i;
    assign w_neg  = (w_funct3[2] && w_funct3[1]) ? w_s1 : (w_s1 ^ w_s2);
    assign w_div0 = (op2_i == '0);
    assign w_ovf  = w_funct3[2] && !w_funct3[0] && (op1_i == c_MIN) && (op2_i == '1);
    assign w_special = w_div0 ? (w_funct3[1] ? op1_i : '1)
                              : (w_funct3[1] ? '0 : op1_i);

    logic [2*XLEN-1:0] w_step;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_diff;
    logic [XLEN:0]     w_sum;

    // r_acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        w_step   = r_acc;
        w_rem_sh = '0;
        w_diff   = '0;
        w_sum    = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (r_f3[2]) begin
                w_rem_sh = {w_step[2*XLEN-1:XLEN], w_step[XLEN-1]};
                w_diff   = w_rem_sh - {1'b0, r_opb};
                if (!w_diff[XLEN]) begin
                    w_step = {w_diff[XLEN-1:0], w_step[XLEN-2:0], 1'b1};
                end else begin
                    w_step = {w_rem_sh[XLEN-1:0], w_step[XLEN-2:0], 1'b0};
                end
            end else begin
                w_sum  = {1'b0, w_step[2*XLEN-1:XLEN]} + (w_step[0] ? {1'b0, r_opb} : '0);
                w_step = {w_sum, w_step[XLEN-1:1]};
            end
        end
    end

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_mdu_res;

    assign w_prod = r_neg ? -w_step : w_step;
    assign w_quo  = r_neg ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
    assign w_rem  = r_neg ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];

    always_comb begin
        case (r_f3)
            3'b000:          w_mdu_res = w_prod[XLEN-1:0];
            3'b100, 3'b101:  w_mdu_res = w_quo;
            3'b110, 3'b111:  w_mdu_res = w_rem;
            default:         w_mdu_res = w_prod[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opb      <= '0;
            r_f3       <= '0;
            r_neg      <= 1'b0;
            r_op_we    <= 1'b0;
            r_op_waddr <= '0;
            r_valid    <= 1'b0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
        end else begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            if (flush_i) begin
                r_state <= c_IDLE;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (valid_i) begin
                            if (w_is_m && w_funct3[2] && (w_div0 || w_ovf)) begin
                                r_valid <= 1'b1;
                                r_we    <= reg_we_i;
                                r_waddr <= reg_waddr_i;
                                r_wdata <= w_special;
                            end else if (w_is_m) begin
                                r_state    <= c_ITERATE;
                                r_cnt      <= '0;
                                r_acc      <= {{XLEN{1'b0}}, w_mag1};
                                r_opb      <= w_mag2;
                                r_f3       <= w_funct3;
                                r_neg      <= w_neg;
                                r_op_we    <= reg_we_i;
                                r_op_waddr <= reg_waddr_i;
                            end else if (w_alu_ok) begin
                                r_valid <= 1'b1;
                                r_we    <= reg_we_i;
                                r_waddr <= reg_waddr_i;
                                r_wdata <= w_alu_res;
                            end else begin
                                r_valid <= 1'b1;
                                r_waddr <= '0;
                                r_wdata <= '0;
                            end
                        end
                    end
                    c_ITERATE: begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + 1'b1;
                        // Result is taken from the final step directly so DONE carries the strobe
                        if (r_cnt == c_LAST) begin
                            r_state <= c_DONE;
                            r_valid <= 1'b1;
                            r_we    <= r_op_we;
                            r_waddr <= r_op_waddr;
                            r_wdata <= w_mdu_res;
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

    assign ready_o     = (r_state == c_IDLE);
    assign busy_o      = (r_state != c_IDLE);
    assign valid_o     = r_valid;
    assign reg_we_o    = r_we;
    assign reg_waddr_o = r_waddr;
    assign reg_wdata_o = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_exe_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : tb_exe_muldiv
// Brief   : Directed vector bench for exe_muldiv at 1 and 4 bits per cycle.
// Rev     : 1.0
// ============================================================================

module tb_exe_muldiv;

    localparam logic [6:0] c_OP  = 7'b0110011;
    localparam logic [6:0] c_IMM = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        valid_i;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] inst;
    logic        we_i;
    logic [4:0]  waddr_i;

    logic        d1_ready, d1_valid, d1_we, d1_busy;
    logic [4:0]  d1_waddr;
    logic [31:0] d1_wdata;
    logic        d4_ready, d4_valid, d4_we, d4_busy;
    logic [4:0]  d4_waddr;
    logic [31:0] d4_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exe_muldiv #(.XLEN(32), .RADDR_WIDTH(5), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_i), .ready_o(d1_ready),
        .op1_i(op1), .op2_i(op2), .inst_i(inst), .reg_we_i(we_i), .reg_waddr_i(waddr_i),
        .valid_o(d1_valid), .reg_we_o(d1_we), .reg_waddr_o(d1_waddr),
        .reg_wdata_o(d1_wdata), .busy_o(d1_busy)
    );

    exe_muldiv #(.XLEN(32), .RADDR_WIDTH(5), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_i), .ready_o(d4_ready),
        .op1_i(op1), .op2_i(op2), .inst_i(inst), .reg_we_i(we_i), .reg_waddr_i(waddr_i),
        .valid_o(d4_valid), .reg_we_o(d4_we), .reg_waddr_o(d4_waddr),
        .reg_wdata_o(d4_wdata), .busy_o(d4_busy)
    );

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        we;
        logic [4:0]  waddr;
        logic        exp_we;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_data;
        int          exp_lat;
        bit          b4;
    } vec_t;

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [6:0] opc);
        return {f7, 10'd0, f3, 5'd0, opc};
    endfunction

    function automatic vec_t mk(input string n, input logic [31:0] in, input logic [31:0] a,
                                input logic [31:0] b, input logic w, input logic [4:0] wa,
                                input logic ew, input logic [4:0] ewa, input logic [31:0] ed,
                                input int lat, input bit b4);
        vec_t v;
        v.name = n; v.inst = in; v.op1 = a; v.op2 = b; v.we = w; v.waddr = wa;
        v.exp_we = ew; v.exp_waddr = ewa; v.exp_data = ed; v.exp_lat = lat; v.b4 = b4;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(d1_ready && d4_ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(d1_ready && d4_ready)) chk("wait_idle timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input vec_t v);
        int   lat;
        logic got;
        valid_i = 1'b1; inst = v.inst; op1 = v.op1; op2 = v.op2;
        we_i = v.we; waddr_i = v.waddr;
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 1;
        got = v.b4 ? d4_valid : d1_valid;
        while (!got && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            got = v.b4 ? d4_valid : d1_valid;
        end
        chk({v.name, " valid"}, 64'(got), 64'd1);
        chk({v.name, " latency"}, 64'(lat), 64'(v.exp_lat));
        chk({v.name, " we"}, 64'(v.b4 ? d4_we : d1_we), 64'(v.exp_we));
        chk({v.name, " waddr"}, 64'(v.b4 ? d4_waddr : d1_waddr), 64'(v.exp_waddr));
        chk({v.name, " wdata"}, 64'(v.b4 ? d4_wdata : d1_wdata), 64'(v.exp_data));
        @(posedge clk); #1;
        chk({v.name, " pulse"}, 64'(v.b4 ? {d4_valid, d4_we} : {d1_valid, d1_we}), 64'd0);
        wait_idle();
    endtask

    task automatic chk_cleared(input string name);
        chk({name, " d1 valid"}, 64'(d1_valid), 64'd0);
        chk({name, " d1 we"},    64'(d1_we),    64'd0);
        chk({name, " d1 waddr"}, 64'(d1_waddr), 64'd0);
        chk({name, " d1 wdata"}, 64'(d1_wdata), 64'd0);
        chk({name, " d1 busy"},  64'(d1_busy),  64'd0);
        chk({name, " d1 ready"}, 64'(d1_ready), 64'd1);
        chk({name, " d4 state"}, 64'({d4_valid, d4_we, d4_busy, d4_ready}), 64'b0001);
        chk({name, " d4 data"},  64'({d4_waddr, d4_wdata}), 64'd0);
    endtask

    initial begin
        vec_t vecs[$];
        int   nvalid;
        logic [31:0] cap;

        rst = 1'b1; flush = 1'b0; valid_i = 1'b0;
        op1 = '0; op2 = '0; inst = '0; we_i = 1'b0; waddr_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_cleared("reset");

        vecs.push_back(mk("addi",    enc(7'h00,3'b000,c_IMM), 32'd5, 32'hFFFFFFFD, 1, 5'd3, 1, 5'd3, 32'd2, 1, 0));
        vecs.push_back(mk("slt",     enc(7'h00,3'b010,c_OP), 32'hFFFFFFFF, 32'd1, 1, 5'd4, 1, 5'd4, 32'd1, 1, 0));
        vecs.push_back(mk("sltu",    enc(7'h00,3'b011,c_OP), 32'hFFFFFFFF, 32'd1, 1, 5'd5, 1, 5'd5, 32'd0, 1, 0));
        vecs.push_back(mk("sub",     enc(7'h20,3'b000,c_OP), 32'd10, 32'd3, 1, 5'd6, 1, 5'd6, 32'd7, 1, 0));
        vecs.push_back(mk("sra",     enc(7'h20,3'b101,c_OP), 32'h80000000, 32'd4, 1, 5'd7, 1, 5'd7, 32'hF8000000, 1, 0));
        vecs.push_back(mk("srli",    enc(7'h00,3'b101,c_IMM), 32'h80000000, 32'h24, 1, 5'd8, 1, 5'd8, 32'h08000000, 1, 0));
        vecs.push_back(mk("sll",     enc(7'h00,3'b001,c_OP), 32'd1, 32'h3F, 1, 5'd9, 1, 5'd9, 32'h80000000, 1, 0));
        vecs.push_back(mk("xori",    enc(7'h00,3'b100,c_IMM), 32'hFF00FF00, 32'h0F0F0F0F, 1, 5'd10, 1, 5'd10, 32'hF00FF00F, 1, 0));
        vecs.push_back(mk("or",      enc(7'h00,3'b110,c_OP), 32'hF0, 32'h0F, 1, 5'd11, 1, 5'd11, 32'hFF, 1, 0));
        vecs.push_back(mk("andi",    enc(7'h00,3'b111,c_IMM), 32'hF0, 32'h3C, 1, 5'd12, 1, 5'd12, 32'h30, 1, 0));
        vecs.push_back(mk("sltiu",   enc(7'h00,3'b011,c_IMM), 32'd3, 32'hFFFFFFFF, 1, 5'd13, 1, 5'd13, 32'd1, 1, 0));
        vecs.push_back(mk("add_nowe",enc(7'h00,3'b000,c_OP), 32'h7FFFFFFF, 32'd1, 0, 5'd14, 0, 5'd14, 32'h80000000, 1, 0));
        vecs.push_back(mk("bad_f7",  enc(7'h20,3'b001,c_OP), 32'd1, 32'd1, 1, 5'd15, 0, 5'd0, 32'd0, 1, 0));
        vecs.push_back(mk("bad_opc", enc(7'h00,3'b000,7'b0000011), 32'd1, 32'd1, 1, 5'd16, 0, 5'd0, 32'd0, 1, 0));
        vecs.push_back(mk("div",     enc(7'h01,3'b100,c_OP), 32'd7, 32'hFFFFFFFE, 1, 5'd17, 1, 5'd17, 32'hFFFFFFFD, 33, 0));
        vecs.push_back(mk("rem",     enc(7'h01,3'b110,c_OP), 32'd7, 32'hFFFFFFFE, 1, 5'd18, 1, 5'd18, 32'd1, 33, 0));
        vecs.push_back(mk("mulhu",   enc(7'h01,3'b011,c_OP), 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 5'd19, 1, 5'd19, 32'hFFFFFFFE, 33, 0));
        vecs.push_back(mk("mul",     enc(7'h01,3'b000,c_OP), 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 5'd20, 1, 5'd20, 32'd1, 33, 0));
        vecs.push_back(mk("mulh",    enc(7'h01,3'b001,c_OP), 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 5'd21, 1, 5'd21, 32'd0, 33, 0));
        vecs.push_back(mk("mulhsu",  enc(7'h01,3'b010,c_OP), 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 5'd22, 1, 5'd22, 32'hFFFFFFFF, 33, 0));
        vecs.push_back(mk("mul_neg", enc(7'h01,3'b000,c_OP), 32'hFFFFFFFD, 32'd7, 1, 5'd23, 1, 5'd23, 32'hFFFFFFEB, 33, 0));
        vecs.push_back(mk("div_neg", enc(7'h01,3'b100,c_OP), 32'hFFFFFFF9, 32'd2, 1, 5'd24, 1, 5'd24, 32'hFFFFFFFD, 33, 0));
        vecs.push_back(mk("rem_neg", enc(7'h01,3'b110,c_OP), 32'hFFFFFFF9, 32'd2, 1, 5'd25, 1, 5'd25, 32'hFFFFFFFF, 33, 0));
        vecs.push_back(mk("divu",    enc(7'h01,3'b101,c_OP), 32'd100, 32'd7, 1, 5'd26, 1, 5'd26, 32'd14, 33, 0));
        vecs.push_back(mk("remu",    enc(7'h01,3'b111,c_OP), 32'd100, 32'd7, 1, 5'd27, 1, 5'd27, 32'd2, 33, 0));
        vecs.push_back(mk("divu_z",  enc(7'h01,3'b101,c_OP), 32'd1234, 32'd0, 1, 5'd28, 1, 5'd28, 32'hFFFFFFFF, 1, 0));
        vecs.push_back(mk("remu_z",  enc(7'h01,3'b111,c_OP), 32'd1234, 32'd0, 1, 5'd29, 1, 5'd29, 32'd1234, 1, 0));
        vecs.push_back(mk("rem_z",   enc(7'h01,3'b110,c_OP), 32'hFFFFFFFB, 32'd0, 1, 5'd30, 1, 5'd30, 32'hFFFFFFFB, 1, 0));
        vecs.push_back(mk("div_ovf", enc(7'h01,3'b100,c_OP), 32'h80000000, 32'hFFFFFFFF, 1, 5'd31, 1, 5'd31, 32'h80000000, 1, 0));
        vecs.push_back(mk("rem_ovf", enc(7'h01,3'b110,c_OP), 32'h80000000, 32'hFFFFFFFF, 1, 5'd1, 1, 5'd1, 32'd0, 1, 0));
        vecs.push_back(mk("mulhu_b4",enc(7'h01,3'b011,c_OP), 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 5'd2, 1, 5'd2, 32'hFFFFFFFE, 9, 1));
        vecs.push_back(mk("mul_b4",  enc(7'h01,3'b000,c_OP), 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 5'd3, 1, 5'd3, 32'd1, 9, 1));
        vecs.push_back(mk("div_b4",  enc(7'h01,3'b100,c_OP), 32'd7, 32'hFFFFFFFE, 1, 5'd4, 1, 5'd4, 32'hFFFFFFFD, 9, 1));

        for (int i = 0; i < vecs.size(); i++) run_op(vecs[i]);

        // Flush on the 10th iteration edge of a DIV
        valid_i = 1'b1; inst = enc(7'h01,3'b100,c_OP); op1 = 32'd7; op2 = 32'hFFFFFFFE;
        we_i = 1'b1; waddr_i = 5'd9;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush ready", 64'(d1_ready), 64'd1);
        chk("flush busy", 64'(d1_busy), 64'd0);
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            if (d1_valid) nvalid++;
            @(posedge clk); #1;
        end
        chk("flush no valid", 64'(nvalid), 64'd0);

        // Flush together with valid in IDLE drops the op
        valid_i = 1'b1; flush = 1'b1; inst = enc(7'h00,3'b000,c_OP); op1 = 32'd1; op2 = 32'd1;
        @(posedge clk); #1;
        valid_i = 1'b0; flush = 1'b0;
        chk("flush idle valid", 64'(d1_valid), 64'd0);
        @(posedge clk); #1;
        chk("flush idle later", 64'({d1_valid, d1_ready}), 64'b01);

        // Offers while busy are ignored; only the DIVU result appears
        valid_i = 1'b1; inst = enc(7'h01,3'b101,c_OP); op1 = 32'd100; op2 = 32'd7;
        we_i = 1'b1; waddr_i = 5'd11;
        @(posedge clk); #1;
        inst = enc(7'h00,3'b000,c_OP); op1 = 32'd1; op2 = 32'd1; waddr_i = 5'd12;
        repeat (5) @(posedge clk);
        #1;
        valid_i = 1'b0;
        nvalid = 0; cap = '0;
        for (int i = 0; i < 50; i++) begin
            if (d1_valid) begin nvalid++; cap = d1_wdata; end
            @(posedge clk); #1;
        end
        chk("busy ignore count", 64'(nvalid), 64'd1);
        chk("busy ignore data", 64'(cap), 64'd14);
        wait_idle();

        // Reset in the middle of a MUL, with valid and flush also high
        valid_i = 1'b1; inst = enc(7'h01,3'b011,c_OP); op1 = 32'hFFFFFFFF; op2 = 32'hFFFFFFFF;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1; valid_i = 1'b1; flush = 1'b1; inst = enc(7'h00,3'b000,c_OP);
        @(posedge clk); #1;
        rst = 1'b0; valid_i = 1'b0; flush = 1'b0;
        chk_cleared("mid_rst");
        run_op(mk("add_after_rst", enc(7'h00,3'b000,c_OP), 32'd3, 32'd4, 1, 5'd2, 1, 5'd2, 32'd7, 1, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

`default_nettype wire
